// File: rtl/mrr_decoded_framer.sv
// mrr_decoded_framer: buffers one decoded packet, then emits it behind a
// {magic,seq,len} word and a 64-bit capture timestamp; oversize packets are dropped.
module mrr_decoded_framer #(
  parameter int          DEPTH_LOG2 = 6,
  parameter logic [15:0] MAGIC      = 16'hA5A5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] cur_time,
  input  logic [31:0] i_tdata,
  input  logic        i_tvalid,
  input  logic        i_tlast,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tvalid,
  output logic        o_tlast,
  input  logic        o_tready,
  output logic [15:0] drop_count,
  output logic        busy
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_DROP, S_HDR0, S_HDR1, S_HDR2, S_PAYLOAD} state_t;
  state_t r_state, w_next;
  logic [DEPTH_LOG2:0] r_len;
  logic [DEPTH_LOG2-1:0] r_rd, w_wa;
  logic [7:0] r_seq;
  logic [63:0] r_ts;
  logic [31:0] r_mem [DEPTH];
  logic w_in, w_out, w_full, w_last, w_wr;
  assign i_tready = r_state == S_IDLE || r_state == S_COLLECT || r_state == S_DROP;
  assign o_tvalid = r_state == S_HDR0 || r_state == S_HDR1 || r_state == S_HDR2 || r_state == S_PAYLOAD;
  assign busy = r_state != S_IDLE;
  assign w_in = i_tvalid & i_tready;
  assign w_out = o_tvalid & o_tready;
  assign w_full = r_len == FULL;
  assign w_last = (r_len - ONE) == {1'b0, r_rd};
  assign w_wr = w_in && (r_state == S_IDLE || (r_state == S_COLLECT && !w_full));
  assign w_wa = r_state == S_IDLE ? '0 : r_len[DEPTH_LOG2-1:0];
  assign o_tlast = r_state == S_PAYLOAD && w_last;
  // the payload buffer is a register array, so PAYLOAD reads combinationally at full rate
  assign o_tdata = r_state == S_HDR0    ? {MAGIC, r_seq, 8'(r_len)} :
                   r_state == S_HDR1    ? r_ts[63:32] :
                   r_state == S_HDR2    ? r_ts[31:0] :
                   r_state == S_PAYLOAD ? r_mem[r_rd] : '0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = w_in ? (i_tlast ? S_HDR0 : S_COLLECT) : S_IDLE;
      S_COLLECT: w_next = !w_in ? S_COLLECT :
                          w_full ? (i_tlast ? S_IDLE : S_DROP) : (i_tlast ? S_HDR0 : S_COLLECT);
      S_DROP:    w_next = w_in && i_tlast ? S_IDLE : S_DROP;
      S_HDR0:    w_next = w_out ? S_HDR1 : S_HDR0;
      S_HDR1:    w_next = w_out ? S_HDR2 : S_HDR1;
      S_HDR2:    w_next = w_out ? S_PAYLOAD : S_HDR2;
      S_PAYLOAD: w_next = w_out && w_last ? S_IDLE : S_PAYLOAD;
      default:   w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_wa] <= i_tdata;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_rd       <= '0;
      r_seq      <= '0;
      r_ts       <= '0;
      drop_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_in && r_state == S_IDLE) begin
        r_len <= ONE;
        r_ts  <= cur_time;
      end else if (w_in && r_state == S_COLLECT && !w_full) r_len <= r_len + ONE;
      if (w_in && r_state == S_COLLECT && w_full && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
      if (w_out && r_state == S_PAYLOAD) begin
        r_rd <= w_last ? '0 : r_rd + 1'b1;
        if (w_last) r_seq <= r_seq + 1'b1;
      end
    end
  end
endmodule

// File: doc/mrr_decoded_framer.md
# mrr_decoded_framer

Packetizes the decoded-bit word stream that the MRR header/loopback pathway produces (`o_decoded_tdata/tvalid/tlast`) into self-describing host packets. Each packet is a 3-word header followed by the buffered payload: magic plus sequence plus length, then a 64-bit capture timestamp. Packets that overflow the payload buffer are dropped and counted. The block sits between the decoder output and the host-facing AXI-Stream mux.

## Interface
- `DEPTH_LOG2`, default 6. Payload buffer depth is 2^DEPTH_LOG2 words. Legal range is 1..8.
- `MAGIC`, default 16'hA5A5. Upper half of header word 0.
- `clk` in, 1. Sole clock.
- `rst` in, 1. Reset, synchronous and active-low. State is cleared on a rising `clk` edge while `rst`=0.
- `cur_time` in, 64. Free-running time counter.
- `i_tdata` in, 32. Decoded payload word.
- `i_tvalid` in, 1. Payload word valid.
- `i_tlast` in, 1. Last word of a decoded packet.
- `i_tready` out, 1. Payload accept.
- `o_tdata` out, 32. Framed output word.
- `o_tvalid` out, 1. Output valid.
- `o_tlast` out, 1. Last word of a framed packet.
- `o_tready` in, 1. Downstream accept.
- `drop_count` out, 16. Count of dropped packets. Saturates at 16'hFFFF.
- `busy` out, 1. High in any state other than IDLE.

## Operation
- Input transfer: `i_tvalid & i_tready`. Output transfer: `o_tvalid & o_tready`.
- States: IDLE, COLLECT, DROP, HDR0, HDR1, HDR2, PAYLOAD.
- `i_tready` is 1 in IDLE, COLLECT and DROP. It is 0 in HDR0..PAYLOAD, so upstream stalls while a packet is emitted.
- IDLE, on input transfer:
  - Write the word at buffer address 0 and set `len`=1.
  - Latch `ts`←`cur_time` from that same cycle.
  - Next state: HDR0 if `i_tlast`, else COLLECT.
- COLLECT, on input transfer:
  - If `len` < 2^DEPTH_LOG2: write the word at address `len` and set `len`←`len`+1. Next state: HDR0 if `i_tlast`, else COLLECT.
  - If `len` = 2^DEPTH_LOG2 (buffer full): discard the word and increment `drop_count` (saturating). Next state: IDLE if `i_tlast`, else DROP.
- DROP: discard every input transfer. Go to IDLE on the transfer that carries `i_tlast`.
- `len` is held in DEPTH_LOG2+1 bits. Header length field = `len` truncated to 8 bits; it equals `len` exactly because depth ≤ 256, except at 256 words, which is reported as 8'h00.
- Header words:
  - HDR0: `{MAGIC, seq[7:0], len[7:0]}`.
  - HDR1: `ts[63:32]`.
  - HDR2: `ts[31:0]`.
- Each header state advances on an output transfer: HDR0→HDR1→HDR2→PAYLOAD.
- PAYLOAD:
  - Emit buffer words at addresses 0..`len`-1, one per output transfer.
  - Assert `o_tlast` with address `len`-1.
  - On that last transfer: `seq`←`seq`+1 (mod 256) and go to IDLE.
- `seq` counts emitted packets only. Dropped packets do not advance it.
- `o_tvalid` is 1 in HDR0..PAYLOAD, 0 otherwise. `o_tlast` is 0 outside PAYLOAD.
- AXI rule: `o_tdata`/`o_tlast` are held stable while `o_tvalid & !o_tready`. `o_tvalid` is never retracted once asserted until its word transfers.
- Buffer: single-port-per-side RAM or register array. Read latency is absorbed so that PAYLOAD can sustain one word per cycle.
- Reset values:
  - State: IDLE. `len`, `seq`, `drop_count`, `ts`: 0.
  - Outputs: `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0, `busy`=0.
  - `i_tready`=1 from the first cycle after reset deasserts.
  - Reset asserted mid-packet abandons the packet without counting a drop.

## Timing
- `ts` is the value of `cur_time` in the same cycle as the packet's first input transfer.
- HDR0 `o_tvalid` rises on the cycle after the input transfer carrying `i_tlast`.
- With `o_tready` held at 1, a `len`-word packet occupies the output for exactly 3+`len` consecutive cycles. `i_tready` returns to 1 on the cycle after the `o_tlast` transfer.
- The full-buffer check uses the pre-increment `len`: word number 2^DEPTH_LOG2 is stored, word number 2^DEPTH_LOG2+1 triggers the drop.
- A packet of exactly 2^DEPTH_LOG2 words ending with `i_tlast` is emitted, not dropped.
- `drop_count` updates on the cycle after the overflowing transfer.
- `i_tlast` on the overflowing word returns to IDLE directly, without passing through DROP.

## Test plan
- **Single word**, `o_tready`=1: inject `i_tdata`=32'hDEADBEEF with `i_tlast`, `cur_time`=64'h0000_0001_0000_0010 on that cycle → output 32'hA5A5_0001, 32'h0000_0001, 32'h0000_0010, 32'hDEADBEEF (`o_tlast`); next packet header carries `seq`=1.
- **Exact fill**, DEPTH_LOG2=6: 64 words 0..63, `i_tlast` on word 63 → header 32'hA5A5_0040, then 64 payload words in order; `drop_count`=0.
- **Overflow**: 70-word packet → no output; `drop_count`=1; `seq` unchanged; a following 2-word packet is emitted with `seq`=0.
- **Backpressure**: `o_tready` random at 50% duty during a 5-word packet → all 8 words delivered in order; `o_tdata` is stable across every stalled cycle; `i_tready`=0 throughout emission.
- **Wrap and saturation**: 256 emitted packets → the 257th header has `seq`=0; forcing 65536 drops → `drop_count` holds 16'hFFFF.
- **Mid-packet reset**: `rst`=0 after 3 COLLECT words → next cycle all outputs are at reset values; `drop_count`=0; a subsequent 1-word packet frames correctly with `seq`=0.
